// File: rtl/fifo_wb_writer_if.sv
// -----------------------------------------------------------------------------
// fifo_wb_writer_if
// Wishbone master-side bundle for fifo_wb_writer.
//
// Signals:
//   wb_cyc_o  - bus cycle in progress
//   wb_stb_o  - strobe, a transfer is offered
//   wb_we_o   - write enable
//   wb_adr_o  - 32-bit byte address
//   wb_dat_o  - write data
//   wb_sel_o  - byte selects
//   wb_cti_o  - cycle type identifier
//   wb_ack_i  - slave acknowledge
//
// Modports: master (the writer) and slave (memory / bus fabric).
// -----------------------------------------------------------------------------
interface fifo_wb_writer_if #(
    parameter int DATA_SIZE = 32
);
    logic                 wb_cyc_o;
    logic                 wb_stb_o;
    logic                 wb_we_o;
    logic [31:0]          wb_adr_o;
    logic [DATA_SIZE-1:0] wb_dat_o;
    logic [3:0]           wb_sel_o;
    logic [2:0]           wb_cti_o;
    logic                 wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i
    );
endinterface

// File: rtl/fifo_wb_writer.sv
// -----------------------------------------------------------------------------
// fifo_wb_writer
// Drains an upstream synchronous-read FIFO into a frame buffer over Wishbone.
// Whenever the FIFO holds a full pack of NB_PACK words, one burst of NB_PACK
// single-word writes is issued at consecutive 32-bit addresses. Each word takes
// a LOAD cycle (FIFO read latency) and at least one WRITE cycle.
// Addressing restarts at base_addr on frame_start or after FRAME_WORDS words.
//
// Parameters:
//   DATA_SIZE   - data word width (32)
//   NB_PACK     - words per burst
//   FRAME_WORDS - words per video frame
//
// Ports:
//   clk, nRST          - clock, asynchronous active-low reset
//   fifo_data          - FIFO head word (valid one cycle after a pop)
//   nb_pack_available  - FIFO holds at least NB_PACK words
//   r_ack              - pop strobe, same cycle as the Wishbone acknowledge
//   base_addr          - frame buffer byte address
//   frame_start        - restart addressing at base_addr
//   wb                 - Wishbone master bundle (fifo_wb_writer_if.master)
//   busy               - burst in progress
//   frame_done         - pulse on the acknowledge of the last frame word
//
// Build option: define BURST_CTI_EN to emit incrementing-burst cycle type
// tags (3'b010, 3'b111 on the last word); otherwise wb_cti_o is 3'b000.
// -----------------------------------------------------------------------------
module fifo_wb_writer #(
    parameter int DATA_SIZE   = 32,
    parameter int NB_PACK     = 16,
    parameter int FRAME_WORDS = 76800
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic                 nb_pack_available,
    output logic                 r_ack,
    input  logic [31:0]          base_addr,
    input  logic                 frame_start,
    fifo_wb_writer_if.master     wb,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int WCW = $clog2(NB_PACK + 1);
    localparam int FCW = $clog2(FRAME_WORDS + 1);
    localparam logic [WCW-1:0] NB_LAST    = WCW'(NB_PACK - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [FCW-1:0] frame_cnt;
    logic           start_pend;
    logic [31:0]    pend_base;

    logic ack_word;
    logic last_in_burst;
    logic last_in_frame;

    assign ack_word      = (state == WRITE) && wb.wb_ack_i;
    assign last_in_burst = (word_cnt == NB_LAST);
    assign last_in_frame = (frame_cnt == FRAME_LAST);

    // The pop must coincide with the acknowledge so the FIFO head advances
    // exactly once per written word.
    assign r_ack      = ack_word;
    assign frame_done = ack_word && last_in_frame;

`ifdef BURST_CTI_EN
    assign wb.wb_cti_o = (state != WRITE) ? 3'b000 :
                         (last_in_burst   ? 3'b111 : 3'b010);
`else
    assign wb.wb_cti_o = 3'b000;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            word_cnt    <= '0;
            frame_cnt   <= '0;
            start_pend  <= 1'b0;
            pend_base   <= '0;
            busy        <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= 4'h0;
        end else begin
            // A frame_start seen mid-burst is remembered, together with the
            // base address present at that moment, until the burst ends.
            if (frame_start && state != IDLE) begin
                start_pend <= 1'b1;
                pend_base  <= base_addr;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        wb.wb_adr_o <= base_addr;
                        frame_cnt   <= '0;
                    end
                    if (nb_pack_available) begin
                        state       <= LOAD;
                        word_cnt    <= '0;
                        busy        <= 1'b1;
                        wb.wb_cyc_o <= 1'b1;
                    end
                end

                LOAD: begin
                    wb.wb_dat_o <= fifo_data;
                    wb.wb_stb_o <= 1'b1;
                    wb.wb_we_o  <= 1'b1;
                    wb.wb_sel_o <= 4'hF;
                    state       <= WRITE;
                end

                WRITE: begin
                    if (wb.wb_ack_i) begin
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_sel_o <= 4'h0;
                        word_cnt    <= word_cnt + WCW'(1);
                        if (last_in_frame) begin
                            wb.wb_adr_o <= base_addr;
                            frame_cnt   <= '0;
                        end else begin
                            wb.wb_adr_o <= wb.wb_adr_o + 32'd4;
                            frame_cnt   <= frame_cnt + FCW'(1);
                        end
                        if (last_in_burst) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            wb.wb_cyc_o <= 1'b0;
                            // A pending restart overrides the frame wrap, so
                            // both together still produce a single reload.
                            if (start_pend || frame_start) begin
                                wb.wb_adr_o <= frame_start ? base_addr : pend_base;
                                frame_cnt   <= '0;
                                start_pend  <= 1'b0;
                            end
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wb_writer.sv
module tb_fifo_wb_writer;

    localparam int NBP = 16;
    localparam int FW  = 32;

    logic        clk;
    logic        nRST;
    logic [31:0] fifo_data;
    logic        nb_pack_available;
    logic        r_ack;
    logic [31:0] base_addr;
    logic        frame_start;
    logic        busy;
    logic        frame_done;

    fifo_wb_writer_if wb ();

    fifo_wb_writer #(
        .DATA_SIZE   (32),
        .NB_PACK     (NBP),
        .FRAME_WORDS (FW)
    ) dut (
        .clk               (clk),
        .nRST              (nRST),
        .fifo_data         (fifo_data),
        .nb_pack_available (nb_pack_available),
        .r_ack             (r_ack),
        .base_addr         (base_addr),
        .frame_start       (frame_start),
        .wb                (wb),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO: the head word is a function of the read pointer, which
    // advances on each pop and is not affected by the writer's reset.
    int unsigned fifo_ptr;
    initial fifo_ptr = 0;
    always @(posedge clk) if (r_ack) fifo_ptr <= fifo_ptr + 1;
    assign fifo_data = 32'hD000_0000 + fifo_ptr;

    int n_checks;
    int n_err;
    int unsigned exp_ptr;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        bit          pre_fs;
        logic [31:0] base;
        logic [31:0] exp_start;
        int          wait_word;
        int          nwaits;
        int          fs_word;
        logic [31:0] fs_base;
        int          rst_word;
        int          fd_word;
        logic [31:0] exp_after;
    } row_t;

    row_t rows[8];

    task automatic run_row(input int ri, input row_t r);
        int          cyc_n;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [2:0]  ecti;
        if (r.pre_fs) begin
            base_addr   = r.base;
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            chk32($sformatf("r%0d_idle_fs_adr", ri), wb.wb_adr_o, r.base);
            chk1($sformatf("r%0d_idle_cyc", ri), wb.wb_cyc_o, 1'b0);
        end
        nb_pack_available = 1'b1;
        cyc_n = 0;
        @(negedge clk); cyc_n++;
        chk1($sformatf("r%0d_load_busy", ri), busy, 1'b1);
        chk1($sformatf("r%0d_load_cyc", ri), wb.wb_cyc_o, 1'b1);
        chk1($sformatf("r%0d_load_stb", ri), wb.wb_stb_o, 1'b0);
        for (int k = 0; k < NBP; k++) begin
            @(negedge clk); cyc_n++;
            ea = r.exp_start + 32'(4 * k);
            ed = 32'hD000_0000 + exp_ptr;
`ifdef BURST_CTI_EN
            ecti = (k == NBP - 1) ? 3'b111 : 3'b010;
`else
            ecti = 3'b000;
`endif
            chk1($sformatf("r%0d_w%0d_stb", ri, k), wb.wb_stb_o, 1'b1);
            chk1($sformatf("r%0d_w%0d_we", ri, k), wb.wb_we_o, 1'b1);
            chk1($sformatf("r%0d_w%0d_cyc", ri, k), wb.wb_cyc_o, 1'b1);
            chk32($sformatf("r%0d_w%0d_sel", ri, k), 32'(wb.wb_sel_o), 32'hF);
            chk32($sformatf("r%0d_w%0d_adr", ri, k), wb.wb_adr_o, ea);
            chk32($sformatf("r%0d_w%0d_dat", ri, k), wb.wb_dat_o, ed);
            chk32($sformatf("r%0d_w%0d_cti", ri, k), 32'(wb.wb_cti_o), 32'(ecti));
            if (k == r.fs_word) begin
                base_addr   = r.fs_base;
                frame_start = 1'b1;
            end
            if (k == r.rst_word) begin
                #2 nRST = 1'b0;
                #1;
                chk1("rst_mid_cyc", wb.wb_cyc_o, 1'b0);
                chk1("rst_mid_stb", wb.wb_stb_o, 1'b0);
                chk1("rst_mid_busy", busy, 1'b0);
                wb.wb_ack_i = 1'b1;
                #1 chk1("rst_mid_rack", r_ack, 1'b0);
                wb.wb_ack_i = 1'b0;
                nb_pack_available = 1'b0;
                frame_start = 1'b0;
                @(negedge clk);
                chk32("rst_mid_adr", wb.wb_adr_o, 32'h0);
                chk1("rst_mid_cyc_hold", wb.wb_cyc_o, 1'b0);
                nRST = 1'b1;
                @(negedge clk);
                chk1("rst_rel_idle", busy, 1'b0);
                return;
            end
            if (k == r.wait_word) begin
                for (int w = 0; w < r.nwaits; w++) begin
                    wb.wb_ack_i = 1'b0;
                    #1 chk1($sformatf("r%0d_w%0d_wait%0d_rack", ri, k, w), r_ack, 1'b0);
                    @(negedge clk); cyc_n++;
                    frame_start = 1'b0;
                    chk32($sformatf("r%0d_w%0d_wait%0d_adr", ri, k, w), wb.wb_adr_o, ea);
                    chk32($sformatf("r%0d_w%0d_wait%0d_dat", ri, k, w), wb.wb_dat_o, ed);
                    chk1($sformatf("r%0d_w%0d_wait%0d_stb", ri, k, w), wb.wb_stb_o, 1'b1);
                end
            end
            wb.wb_ack_i = 1'b1;
            if (k == NBP - 1) nb_pack_available = 1'b0;
            #1;
            chk1($sformatf("r%0d_w%0d_rack", ri, k), r_ack, 1'b1);
            chk1($sformatf("r%0d_w%0d_fdone", ri, k), frame_done, k == r.fd_word);
            exp_ptr++;
            @(negedge clk); cyc_n++;
            wb.wb_ack_i = 1'b0;
            frame_start = 1'b0;
            #1;
            chk1($sformatf("r%0d_w%0d_post_rack", ri, k), r_ack, 1'b0);
            chk1($sformatf("r%0d_w%0d_post_stb", ri, k), wb.wb_stb_o, 1'b0);
            if (k < NBP - 1) begin
                chk1($sformatf("r%0d_w%0d_post_cyc", ri, k), wb.wb_cyc_o, 1'b1);
            end else begin
                chk1($sformatf("r%0d_end_busy", ri), busy, 1'b0);
                chk1($sformatf("r%0d_end_cyc", ri), wb.wb_cyc_o, 1'b0);
                chk32($sformatf("r%0d_end_cycles", ri), 32'(cyc_n), 32'(33 + r.nwaits));
            end
        end
        chk32($sformatf("r%0d_next_adr", ri), wb.wb_adr_o, r.exp_after);
        @(negedge clk);
        chk1($sformatf("r%0d_idle_stays", ri), busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        exp_ptr  = 0;
        //        pre  base          start         wait nw  fs  fs_base       rst fd  after
        rows[0] = '{0, 32'h0,        32'h0,        -1, 0, -1, 32'h0,        -1, -1, 32'h40};
        rows[1] = '{1, 32'h1000,     32'h1000,     -1, 0, -1, 32'h0,        -1, -1, 32'h1040};
        rows[2] = '{0, 32'h0,        32'h1040,      5, 3, -1, 32'h0,        -1, 15, 32'h1000};
        rows[3] = '{0, 32'h0,        32'h1000,     -1, 0,  7, 32'h8000,     -1, -1, 32'h8000};
        rows[4] = '{0, 32'h0,        32'h8000,     -1, 0, -1, 32'h0,         9, -1, 32'h0};
        rows[5] = '{0, 32'h0,        32'h0,        -1, 0, -1, 32'h0,        -1, -1, 32'h40};
        rows[6] = '{1, 32'hFFFFFFC0, 32'hFFFFFFC0, -1, 0, -1, 32'h0,        -1, -1, 32'h0};
        rows[7] = '{0, 32'h0,        32'h0,        -1, 0, -1, 32'h0,        -1, 15, 32'hFFFFFFC0};

        nRST              = 1'b0;
        nb_pack_available = 1'b1;
        base_addr         = 32'h0000_1234;
        frame_start       = 1'b1;
        wb.wb_ack_i       = 1'b0;
        repeat (3) @(negedge clk);
        chk1("reset_cyc", wb.wb_cyc_o, 1'b0);
        chk1("reset_stb", wb.wb_stb_o, 1'b0);
        chk1("reset_we", wb.wb_we_o, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_rack", r_ack, 1'b0);
        chk1("reset_fdone", frame_done, 1'b0);
        chk32("reset_adr", wb.wb_adr_o, 32'h0);
        chk32("reset_dat", wb.wb_dat_o, 32'h0);
        chk32("reset_sel", 32'(wb.wb_sel_o), 32'h0);
        chk32("reset_cti", 32'(wb.wb_cti_o), 32'h0);
        nb_pack_available = 1'b0;
        frame_start       = 1'b0;
        base_addr         = 32'h0;
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        chk1("idle_no_req_cyc", wb.wb_cyc_o, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_row(i, rows[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
